shift_reg_universal: RTL and testbench

//  Parametrised universal shift register: hold, shift left, shift right, parallel load, optional rotate.
//  Two ways to drive it: per-cycle operation under enable, or an autonomous burst of N shifts started by one pulse.

---
 rtl/shift_reg_universal_if.sv | 25 ++
 rtl/shift_reg_universal.sv | 77 +++++++
 tb/tb_shift_reg_universal.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shift_reg_universal_if.sv
// shift_reg_universal_if: control, serial and parallel data signals of the universal shift register
interface shift_reg_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             enable;
  logic [1:0]       mode;
  logic             rotate;
  logic             ser_in;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
  modport master (
    output enable, mode, rotate, ser_in, par_in, start, shift_count,
    input  q, ser_out, busy, done
  );
  modport slave (
    input  enable, mode, rotate, ser_in, par_in, start, shift_count,
    output q, ser_out, busy, done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: universal shift register with per-cycle ops under enable and autonomous N-shift bursts
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  shift_reg_universal_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_left;
  logic             rot_lat;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
  logic             is_shift_mode;
  logic             burst_req;
  logic             accept;
  logic             zero_req;
  logic             use_left;
  logic             use_rot;
  logic             fill;
  logic             do_shift;
  logic             do_load;
  logic [WIDTH-1:0] shifted;
  assign bus.q       = q;
  assign bus.ser_out = ser_out;
  assign bus.busy    = busy;
  assign bus.done    = done;
  // A burst uses the direction/rotate latched at acceptance; direct ops use the live inputs
  always_comb begin
    is_shift_mode = bus.mode == 2'b01 || bus.mode == 2'b10;
    burst_req     = state == IDLE && bus.start && is_shift_mode;
    accept        = burst_req && bus.shift_count != '0;
    zero_req      = burst_req && bus.shift_count == '0;
    use_left      = state == SHIFT ? dir_left : bus.mode == 2'b01;
    use_rot       = state == SHIFT ? rot_lat : bus.rotate;
    fill          = use_rot ? (use_left ? q[WIDTH-1] : q[0]) : bus.ser_in;
    shifted       = use_left ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};
    do_shift      = state == SHIFT || (!accept && bus.enable && is_shift_mode);
    do_load       = state == IDLE && bus.enable && bus.mode == 2'b11;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
      rot_lat  <= 1'b0;
      q        <= '0;
      ser_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= zero_req || (state == SHIFT && cnt == CNT_W'(1));
      if (do_shift) begin
        q       <= shifted;
        ser_out <= use_left ? q[WIDTH-1] : q[0];
      end else if (do_load)
        q <= bus.par_in;
      if (accept) begin
        state    <= SHIFT;
        busy     <= 1'b1;
        cnt      <= bus.shift_count;
        dir_left <= bus.mode == 2'b01;
        rot_lat  <= bus.rotate;
      end else if (state == SHIFT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_shift_reg_universal.sv
// tb_shift_reg_universal: directed and randomized checks against a remaining-shift-count reference model
module tb_shift_reg_universal;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq = '0;
  logic mser = 1'b0, mbusy = 1'b0, mdone = 1'b0;
  int rem = 0;
  bit mleft = 1'b0, mrot = 1'b0;
  logic [7:0] exp4 [3] = '{8'h03, 8'h06, 8'h0C};
  shift_reg_universal_if #(.WIDTH(8), .CNT_W(4)) bus ();
  shift_reg_universal #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic shift_model(input bit left, input bit rot);
    logic [7:0] o;
    logic f;
    o = mq;
    f = rot ? (left ? o[7] : o[0]) : bus.ser_in;
    mser = left ? o[7] : o[0];
    mq = left ? 8'((o << 1) | 8'(f)) : 8'((o >> 1) | (8'(f) << 7));
  endtask
  task automatic cyc(input string tag);
    bit req;
    mdone = 1'b0;
    if (rem > 0) begin
      shift_model(mleft, mrot);
      rem--;
      mdone = rem == 0;
    end else begin
      req = bus.start && (bus.mode == 2'd1 || bus.mode == 2'd2);
      if (req && bus.shift_count != 0) begin
        rem = int'(bus.shift_count);
        mleft = bus.mode == 2'd1;
        mrot = bus.rotate;
      end else begin
        mdone = req;
        if (bus.enable && bus.mode == 2'd1) shift_model(1'b1, bus.rotate);
        else if (bus.enable && bus.mode == 2'd2) shift_model(1'b0, bus.rotate);
        else if (bus.enable && bus.mode == 2'd3) mq = bus.par_in;
      end
    end
    mbusy = rem > 0;
    @(posedge clk);
    #1;
    chk({tag, "_q"}, 32'(bus.q), 32'(mq));
    chk({tag, "_ser_out"}, 32'(bus.ser_out), 32'(mser));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(mbusy));
    chk({tag, "_done"}, 32'(bus.done), 32'(mdone));
  endtask
  task automatic model_reset();
    mq = '0; mser = 1'b0; mbusy = 1'b0; mdone = 1'b0; rem = 0;
  endtask
  initial begin
    bus.enable = 1'b0; bus.mode = 2'd0; bus.rotate = 1'b0; bus.ser_in = 1'b0;
    bus.par_in = '0; bus.start = 1'b0; bus.shift_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_ser_out", 32'(bus.ser_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b1;
    // serial fill from the right with ones
    bus.mode = 2'd1; bus.ser_in = 1'b1; bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) cyc("t2");
    chk("t2_full", 32'(bus.q), 32'hFF);
    // load then rotate right
    bus.mode = 2'd3; bus.par_in = 8'hA5;
    cyc("t3_load");
    bus.mode = 2'd2; bus.rotate = 1'b1;
    cyc("t3_rot");
    chk("t3_q", 32'(bus.q), 32'hD2);
    chk("t3_ser", 32'(bus.ser_out), 32'h1);
    // rotating burst of 3 while enable toggles and mode is changed
    bus.mode = 2'd3; bus.par_in = 8'h81;
    cyc("t4_load");
    bus.enable = 1'b0; bus.start = 1'b1; bus.mode = 2'd1; bus.rotate = 1'b1; bus.shift_count = 4'd3;
    cyc("t4_acc");
    chk("t4_acc_q", 32'(bus.q), 32'h81);
    bus.start = 1'b0; bus.mode = 2'd2; bus.rotate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enable = ~bus.enable;
      cyc("t4_run");
      chk("t4_seq", 32'(bus.q), 32'(exp4[i]));
      chk("t4_busy", 32'(bus.busy), (i < 2) ? 32'h1 : 32'h0);
    end
    chk("t4_done", 32'(bus.done), 32'h1);
    bus.enable = 1'b0; bus.mode = 2'd0;
    cyc("t4_post");
    chk("t4_done_clr", 32'(bus.done), 32'h0);
    // zero-count start, then start pulsed during a busy burst
    bus.start = 1'b1; bus.mode = 2'd1; bus.shift_count = 4'd0;
    cyc("t5_zero");
    chk("t5_zero_done", 32'(bus.done), 32'h1);
    chk("t5_zero_q", 32'(bus.q), 32'h0C);
    bus.start = 1'b0;
    cyc("t5_idle");
    bus.start = 1'b1; bus.mode = 2'd2; bus.rotate = 1'b1; bus.shift_count = 4'd4;
    cyc("t5_acc");
    bus.shift_count = 4'd9; bus.mode = 2'd1;
    cyc("t5_b1");
    cyc("t5_b2");
    bus.start = 1'b0;
    cyc("t5_b3");
    cyc("t5_b4");
    chk("t5_total", 32'(bus.q), 32'hC0);
    chk("t5_done", 32'(bus.done), 32'h1);
    bus.mode = 2'd0;
    cyc("t5_post");
    // reset in the middle of a burst
    bus.mode = 2'd3; bus.par_in = 8'hFF; bus.enable = 1'b1;
    cyc("t6_load");
    bus.enable = 1'b0; bus.mode = 2'd1; bus.ser_in = 1'b0; bus.rotate = 1'b0;
    bus.start = 1'b1; bus.shift_count = 4'd5;
    cyc("t6_acc");
    bus.start = 1'b0;
    cyc("t6_s1");
    cyc("t6_s2");
    chk("t6_pre", 32'(bus.q), 32'hFC);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_q", 32'(bus.q), 32'h0);
    chk("t6_async_busy", 32'(bus.busy), 32'h0);
    chk("t6_async_done", 32'(bus.done), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("t6_nodone", 32'(bus.done), 32'h0);
    reset = 1'b1;
    bus.mode = 2'd3; bus.par_in = 8'h01; bus.enable = 1'b1;
    cyc("t6_load1");
    bus.enable = 1'b0; bus.mode = 2'd1; bus.start = 1'b1; bus.shift_count = 4'd1;
    cyc("t6_acc1");
    bus.start = 1'b0; bus.mode = 2'd0;
    cyc("t6_shift1");
    chk("t6_q02", 32'(bus.q), 32'h02);
    chk("t6_done1", 32'(bus.done), 32'h1);
    cyc("t6_post");
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.mode = 2'($urandom_range(0, 3));
      bus.enable = 1'($urandom_range(0, 1));
      bus.rotate = 1'($urandom_range(0, 1));
      bus.ser_in = 1'($urandom_range(0, 1));
      bus.par_in = 8'($urandom);
      bus.start = $urandom_range(0, 4) == 0;
      bus.shift_count = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
